// File: rtl/timer_req_pkg.sv
// Shared constants for the counter-request stage: counter ids, source bit
// positions in the pending/lost vectors, FSM encoding and id/mask helpers.
package timer_req_pkg;

  localparam int unsigned ID_W = 3;
  localparam int unsigned NSRC = 5;

  localparam logic [ID_W-1:0] TID_NONE = 3'd0;
  localparam logic [ID_W-1:0] TID_T1   = 3'd1;
  localparam logic [ID_W-1:0] TID_T3   = 3'd3;
  localparam logic [ID_W-1:0] TID_T4   = 3'd4;
  localparam logic [ID_W-1:0] TID_T5   = 3'd5;
  localparam logic [ID_W-1:0] TID_T6   = 3'd6;

  localparam int unsigned B_T1 = 0;
  localparam int unsigned B_T3 = 1;
  localparam int unsigned B_T4 = 2;
  localparam int unsigned B_T5 = 3;
  localparam int unsigned B_T6 = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } req_state_e;

  // Fixed priority T6 > T5 > T4 > T3 > T1.
  function automatic logic [ID_W-1:0] pick_id(input logic [NSRC-1:0] p);
    logic [ID_W-1:0] id;
    id = TID_NONE;
    if (p[B_T6])      id = TID_T6;
    else if (p[B_T5]) id = TID_T5;
    else if (p[B_T4]) id = TID_T4;
    else if (p[B_T3]) id = TID_T3;
    else if (p[B_T1]) id = TID_T1;
    return id;
  endfunction

  function automatic logic [NSRC-1:0] id_to_mask(input logic [ID_W-1:0] id);
    logic [NSRC-1:0] m;
    m = '0;
    case (id)
      TID_T1:  m[B_T1] = 1'b1;
      TID_T3:  m[B_T3] = 1'b1;
      TID_T4:  m[B_T4] = 1'b1;
      TID_T5:  m[B_T5] = 1'b1;
      TID_T6:  m[B_T6] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/req_edge_detect.sv
// Registered rising-edge detector; the rise strobe is combinational from f_i
// so a pending bit can be set at the same edge the input is first seen high.
module req_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic f_i,
  output logic rise_c_o
);

  logic f_q;

  always_ff @(posedge clk) begin
    if (rst) f_q <= 1'b0;
    else     f_q <= f_i;
  end

  assign rise_c_o = f_i & ~f_q;

endmodule

// File: rtl/timer_count_request.sv
// Turns scaler F-pulse rises into pending counter requests, offers them one
// at a time in fixed priority over valid/ack, and accounts for lost events.
module timer_count_request
  import timer_req_pkg::*;
#(
  parameter int unsigned LOST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F10B,
  input  logic              F09B,
  input  logic              F10A,
  input  logic              F06B,
  input  logic              T6ON,
  input  logic              req_ack,
  input  logic              clr_lost,
  output logic              req_valid,
  output logic [ID_W-1:0]   req_id,
  output logic [NSRC-1:0]   lost_flags,
  output logic [LOST_W-1:0] lost_count
);

  localparam logic [LOST_W-1:0] LOST_MAX = '1;

  logic rise_f10b, rise_f09b, rise_f10a, rise_f06b;

  req_edge_detect u_ed_f10b (.clk(clk), .rst(rst), .f_i(F10B), .rise_c_o(rise_f10b));
  req_edge_detect u_ed_f09b (.clk(clk), .rst(rst), .f_i(F09B), .rise_c_o(rise_f09b));
  req_edge_detect u_ed_f10a (.clk(clk), .rst(rst), .f_i(F10A), .rise_c_o(rise_f10a));
  req_edge_detect u_ed_f06b (.clk(clk), .rst(rst), .f_i(F06B), .rise_c_o(rise_f06b));

  req_state_e        state_q, state_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   flags_q, flags_d;
  logic [LOST_W-1:0] count_q, count_d;

  logic [NSRC-1:0]   set_c, ack_c, loss_c, eligible_c;
  logic [LOST_W:0]   nloss_c, sum_c;
  logic              t6_offered_c;

  always_comb begin
    set_c         = '0;
    set_c[B_T1]   = rise_f10b;
    set_c[B_T3]   = rise_f10b;
    set_c[B_T4]   = rise_f09b;
    set_c[B_T5]   = rise_f10a;
    set_c[B_T6]   = rise_f06b & T6ON;

    ack_c         = (state_q == S_OFFER && req_ack) ? id_to_mask(req_id_q) : '0;
    // A rise on a bit being acked this cycle re-arms it rather than counting as lost.
    loss_c        = set_c & pending_q & ~ack_c;

    t6_offered_c  = (state_q == S_OFFER) && (req_id_q == TID_T6);
    pending_d     = (pending_q & ~ack_c) | set_c;
    if (!T6ON && !t6_offered_c) pending_d[B_T6] = 1'b0;

    // A T6 bit about to be dropped by T6ON=0 must not be picked up for an offer.
    eligible_c    = pending_q;
    if (!T6ON) eligible_c[B_T6] = 1'b0;

    state_d  = state_q;
    valid_d  = valid_q;
    req_id_d = req_id_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible_c) begin
          state_d  = S_OFFER;
          valid_d  = 1'b1;
          req_id_d = pick_id(eligible_c);
        end
      end
      S_OFFER: begin
        if (req_ack) begin
          state_d  = S_IDLE;
          valid_d  = 1'b0;
          req_id_d = TID_NONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        valid_d  = 1'b0;
        req_id_d = TID_NONE;
      end
    endcase

    nloss_c = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      nloss_c = nloss_c + (LOST_W+1)'(loss_c[i]);
    end
    sum_c   = (clr_lost ? '0 : {1'b0, count_q}) + nloss_c;
    count_d = sum_c[LOST_W] ? LOST_MAX : sum_c[LOST_W-1:0];
    flags_d = (clr_lost ? '0 : flags_q) | loss_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      req_id_q  <= TID_NONE;
      pending_q <= '0;
      flags_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      req_id_q  <= req_id_d;
      pending_q <= pending_d;
      flags_q   <= flags_d;
      count_q   <= count_d;
    end
  end

  assign req_valid  = valid_q;
  assign req_id     = req_id_q;
  assign lost_flags = flags_q;
  assign lost_count = count_q;

endmodule

// File: tb/tb_timer_count_request.sv
// Directed bench for timer_count_request: reset, offer order/latency,
// handshake spacing, loss accounting, saturation and T6ON gating.
module tb_timer_count_request;

  logic       clk = 1'b0;
  logic       rst;
  logic       F10B, F09B, F10A, F06B, T6ON;
  logic       req_ack, clr_lost;
  logic       req_valid;
  logic [2:0] req_id;
  logic [4:0] lost_flags;
  logic [7:0] lost_count;

  int checks = 0;
  int errors = 0;

  timer_count_request #(.LOST_W(8)) dut (
    .clk(clk), .rst(rst),
    .F10B(F10B), .F09B(F09B), .F10A(F10A), .F06B(F06B), .T6ON(T6ON),
    .req_ack(req_ack), .clr_lost(clr_lost),
    .req_valid(req_valid), .req_id(req_id),
    .lost_flags(lost_flags), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer must hold id for 'hold' cycles; ack on the last, then one IDLE cycle.
  task automatic expect_offer(input logic [2:0] id, input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("offer_valid", 32'(req_valid), 32'd1);
      chk("offer_id", 32'(req_id), 32'(id));
      if (i == hold - 1) req_ack = 1'b1;
      tick();
    end
    req_ack = 1'b0;
    chk("post_ack_valid", 32'(req_valid), 32'd0);
    chk("post_ack_id", 32'(req_id), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; F10B = 0; F09B = 0; F10A = 0; F06B = 0; T6ON = 0;
    req_ack = 0; clr_lost = 0;

    // Reset with F inputs toggling
    for (int i = 0; i < 3; i++) begin
      F10B = i[0]; F09B = ~i[0]; F10A = i[0]; F06B = i[0];
      tick();
    end
    rst = 1'b0; F10B = 0; F09B = 0; F10A = 0; F06B = 0;
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_id", 32'(req_id), 32'd0);
    chk("rst_flags", 32'(lost_flags), 32'd0);
    chk("rst_count", 32'(lost_count), 32'd0);
    tick();
    chk("rst_idle1", 32'(req_valid), 32'd0);
    tick();
    chk("rst_idle2", 32'(req_valid), 32'd0);

    // Single F09B rise: valid two edges later with id 4
    F09B = 1; tick(); F09B = 0;
    chk("f09b_lat1", 32'(req_valid), 32'd0);
    tick();
    expect_offer(3'd4, 1);
    chk("f09b_none1", 32'(req_valid), 32'd0);
    tick();
    chk("f09b_none2", 32'(req_valid), 32'd0);

    // F10B with ack held high: id 3, idle, id 1, idle
    F10B = 1; req_ack = 1; tick(); F10B = 0;
    chk("f10b_lat", 32'(req_valid), 32'd0);
    tick();
    chk("f10b_v3", 32'(req_valid), 32'd1);
    chk("f10b_id3", 32'(req_id), 32'd3);
    tick();
    chk("f10b_gap", 32'(req_valid), 32'd0);
    tick();
    chk("f10b_v1", 32'(req_valid), 32'd1);
    chk("f10b_id1", 32'(req_id), 32'd1);
    tick();
    chk("f10b_end", 32'(req_valid), 32'd0);
    req_ack = 0;
    tick();
    chk("f10b_quiet", 32'(req_valid), 32'd0);
    chk("f10b_count", 32'(lost_count), 32'd0);

    // Simultaneous F10A/F09B/F06B with T6ON: order 6,5,4, ack after 5 cycles
    T6ON = 1; F10A = 1; F09B = 1; F06B = 1; tick();
    F10A = 0; F09B = 0; F06B = 0;
    chk("multi_lat", 32'(req_valid), 32'd0);
    tick();
    expect_offer(3'd6, 5);
    expect_offer(3'd5, 5);
    expect_offer(3'd4, 5);
    chk("multi_done", 32'(req_valid), 32'd0);
    chk("multi_count", 32'(lost_count), 32'd0);
    T6ON = 0;

    // Two F10A rises without ack, then clr_lost
    F10A = 1; tick(); F10A = 0; tick();
    F10A = 1; tick(); F10A = 0;
    chk("t5_flags", 32'(lost_flags), 32'h08);
    chk("t5_count", 32'(lost_count), 32'd1);
    chk("t5_held", 32'(req_id), 32'd5);
    clr_lost = 1; tick(); clr_lost = 0;
    chk("clr_flags", 32'(lost_flags), 32'd0);
    chk("clr_count", 32'(lost_count), 32'd0);
    expect_offer(3'd5, 1);
    chk("t5_single", 32'(req_valid), 32'd0);

    // 151 F10B rises unacked: first arms T1/T3, the rest lose 2 each
    for (int i = 0; i < 151; i++) begin
      F10B = 1; tick(); F10B = 0; tick();
      if (i == 9)   chk("sat_mid", 32'(lost_count), 32'd18);
      if (i == 127) chk("sat_254", 32'(lost_count), 32'd254);
      if (i == 128) chk("sat_255", 32'(lost_count), 32'd255);
    end
    chk("sat_final", 32'(lost_count), 32'd255);
    chk("sat_flags", 32'(lost_flags), 32'h03);
    expect_offer(3'd3, 1);
    expect_offer(3'd1, 1);
    chk("sat_drained", 32'(req_valid), 32'd0);

    // F06B with T6ON=0: no request, no loss
    clr_lost = 1; tick(); clr_lost = 0;
    chk("clr2_count", 32'(lost_count), 32'd0);
    F06B = 1; tick(); F06B = 0; tick(); tick();
    chk("t6off_valid", 32'(req_valid), 32'd0);
    chk("t6off_flags", 32'(lost_flags), 32'd0);
    chk("t6off_count", 32'(lost_count), 32'd0);

    // Reset while offering: offer dropped and not replayed
    F10A = 1; tick(); F10A = 0; tick();
    chk("midrst_pre", 32'(req_valid), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("midrst_valid", 32'(req_valid), 32'd0);
    chk("midrst_id", 32'(req_id), 32'd0);
    tick(); tick();
    chk("midrst_noreplay", 32'(req_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
